galaga_missile_fsm: RTL

- Consumes the one-hot ship position (L, C, R) from the ship-movement FSM, plus a FIRE button.
- Launches a single missile in the ship's column and advances it up the playfield one row at a time.
- At the top row, resolves hit or miss against the enemy-occupancy mask.
- Sits between the ship FSM and the score/enemy logic; only one missile is in flight at a time.

---
 rtl/galaga_missile_fsm.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/galaga_missile_fsm.sv
// galaga_missile_fsm: single-missile launcher for the Galaga-style playfield.
// Takes the one-hot ship column and a FIRE button. It launches one missile,
// moves it up ROWS rows (STEP_DIV cycles per row), and resolves hit or miss
// against the top-row enemy mask. After that it waits COOLDOWN cycles before
// it accepts another launch. All outputs come straight from registers.
module galaga_missile_fsm #(
  parameter int ROWS     = 4,
  parameter int STEP_DIV = 2,
  parameter int COOLDOWN = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       fire,
  input  logic       l,
  input  logic       c,
  input  logic       r,
  input  logic [2:0] enemy,
  output logic       active,
  output logic [2:0] col,
  output logic [2:0] row,
  output logic       hit,
  output logic       miss,
  output logic [2:0] kill,
  output logic [1:0] sp
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    FLY     = 2'b01,
    RESOLVE = 2'b10,
    COOL    = 2'b11
  } state_t;

  // Counter widths stay at least 1 bit, so STEP_DIV = 1 and COOLDOWN = 0 are legal.
  localparam int SW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int CW = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;
  localparam logic [SW-1:0] STEP_LAST = SW'(STEP_DIV - 1);
  localparam logic [CW-1:0] COOL_LAST = CW'((COOLDOWN > 0) ? COOLDOWN - 1 : 0);
  localparam logic [2:0]    ROW_TOP   = 3'(ROWS);

  state_t          state_reg, state_next;
  logic [SW-1:0]   step_reg, step_next;
  logic [CW-1:0]   cool_reg, cool_next;
  logic            fire_q_reg;
  logic            active_reg, active_next;
  logic [2:0]      col_reg, col_next;
  logic [2:0]      row_reg, row_next;
  logic            hit_reg, hit_next;
  logic            miss_reg, miss_next;
  logic [2:0]      kill_reg, kill_next;

  logic [2:0]      lcr;
  logic            lcr_onehot;
  logic            fire_edge;
  logic [2:0]      strike;

  assign lcr        = {l, c, r};
  assign lcr_onehot = (lcr == 3'b100) || (lcr == 3'b010) || (lcr == 3'b001);
  assign fire_edge  = fire & ~fire_q_reg;

  // Per-column overlap of the missile column with the live-enemy mask.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_strike
      assign strike[gi] = enemy[gi] & col_reg[gi];
    end
  endgenerate

  // State, counters, fire history and all output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      step_reg   <= '0;
      cool_reg   <= '0;
      fire_q_reg <= 1'b0;
      active_reg <= 1'b0;
      col_reg    <= 3'b000;
      row_reg    <= 3'd0;
      hit_reg    <= 1'b0;
      miss_reg   <= 1'b0;
      kill_reg   <= 3'b000;
    end else begin
      state_reg  <= state_next;
      step_reg   <= step_next;
      cool_reg   <= cool_next;
      fire_q_reg <= fire;
      active_reg <= active_next;
      col_reg    <= col_next;
      row_reg    <= row_next;
      hit_reg    <= hit_next;
      miss_reg   <= miss_next;
      kill_reg   <= kill_next;
    end
  end

  // Next-state and next-output logic. The result pulses default to zero.
  always_comb begin
    state_next  = state_reg;
    step_next   = step_reg;
    cool_next   = cool_reg;
    active_next = active_reg;
    col_next    = col_reg;
    row_next    = row_reg;
    hit_next    = 1'b0;
    miss_next   = 1'b0;
    kill_next   = 3'b000;

    case (state_reg)
      IDLE: begin
        // Only a clean press with an unambiguous ship column launches.
        if (fire_edge && lcr_onehot) begin
          state_next  = FLY;
          col_next    = lcr;
          row_next    = 3'd1;
          active_next = 1'b1;
          step_next   = '0;
        end
      end

      FLY: begin
        // Each row is held for STEP_DIV cycles. From the top row the missile goes to resolution.
        if (step_reg == STEP_LAST) begin
          step_next = '0;
          if (row_reg == ROW_TOP) begin
            state_next = RESOLVE;
          end else begin
            row_next = row_reg + 3'd1;
          end
        end else begin
          step_next = step_reg + SW'(1);
        end
      end

      RESOLVE: begin
        if (|strike) begin
          hit_next  = 1'b1;
          kill_next = col_reg;
        end else begin
          miss_next = 1'b1;
        end
        active_next = 1'b0;
        col_next    = 3'b000;
        row_next    = 3'd0;
        cool_next   = '0;
        if (COOLDOWN == 0) begin
          state_next = IDLE;
        end else begin
          state_next = COOL;
        end
      end

      COOL: begin
        // Fire edges seen here are dropped. They are not carried into IDLE.
        if (cool_reg == COOL_LAST) begin
          cool_next  = '0;
          state_next = IDLE;
        end else begin
          cool_next = cool_reg + CW'(1);
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign active = active_reg;
  assign col    = col_reg;
  assign row    = row_reg;
  assign hit    = hit_reg;
  assign miss   = miss_reg;
  assign kill   = kill_reg;
  assign sp     = state_reg;

endmodule
